// File: rtl/dme_pulse_pair_receiver.sv
// DME pulse-pair receiver: tick-sampled slicer, pair spacing/width validation, range timing.
// Define DME_RX_AVG_EN to slice a 4-tap moving average of adc_in instead of the raw sample.
module dme_pulse_pair_receiver #(
    parameter int DATA_W    = 12,
    parameter int DIV_COUNT = 100,
    parameter int TIMER_W   = 16,
    parameter int MAX_WIDTH = 8,
    parameter int TOL       = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [DATA_W-1:0]  adc_in,
    input  logic [DATA_W-1:0]  threshold,
    input  logic               interrog,
    input  logic [7:0]         spacing,
    input  logic [TIMER_W-1:0] reply_delay,
    input  logic [TIMER_W-1:0] timeout,
    output logic [TIMER_W-1:0] range_cnt,
    output logic               range_valid,
    output logic               pair_det,
    output logic               timeout_err,
    output logic               busy
);

    localparam int DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam int WID_W = $clog2(MAX_WIDTH + 1) + 1;
    localparam int CW    = TIMER_W + 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT1,
        P1,
        GAP,
        P2,
        REPORT
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [DATA_W-1:0]  sample;
    logic               above;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] t1;
    logic [WID_W-1:0]   width;
    logic [TIMER_W-1:0] dt;
    logic [CW-1:0]      dt_x;
    logic [CW-1:0]      sp_x;
    logic [CW-1:0]      tol_x;
    logic               in_tol;
    logic               early;
    logic               late;
    logic               report_now;
    logic               timeout_hit;
    logic               width_full;

    // ---------------- sample tick divider ----------------
    assign tick = (div_cnt == DIV_W'(DIV_COUNT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ---------------- slicer input ----------------
`ifdef DME_RX_AVG_EN
    logic [DATA_W-1:0] tap0;
    logic [DATA_W-1:0] tap1;
    logic [DATA_W-1:0] tap2;
    logic signed [DATA_W+1:0] avg_sum;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tap0 <= '0;
            tap1 <= '0;
            tap2 <= '0;
        end else if (tick) begin
            tap0 <= adc_in;
            tap1 <= tap0;
            tap2 <= tap1;
        end
    end

    always_comb begin
        avg_sum = (DATA_W+2)'($signed(adc_in)) + (DATA_W+2)'($signed(tap0))
                + (DATA_W+2)'($signed(tap1)) + (DATA_W+2)'($signed(tap2));
        sample  = DATA_W'(avg_sum >>> 2);
    end
`else
    assign sample = adc_in;
`endif

    assign above = $signed(sample) > $signed(threshold);

    // ---------------- spacing window ----------------
    // Extended widths keep spacing +/- TOL free of wrap-around at small spacings.
    assign dt     = timer - t1;
    assign dt_x   = CW'(dt);
    assign sp_x   = CW'(spacing);
    assign tol_x  = CW'(TOL);
    assign in_tol = ((dt_x + tol_x) >= sp_x) && (dt_x <= (sp_x + tol_x));
    assign early  = (dt_x + tol_x) < sp_x;
    assign late   = dt_x > (sp_x + tol_x);

    assign width_full  = (width >= WID_W'(MAX_WIDTH));
    assign report_now  = tick && (state == P2) && !above;
    assign timeout_hit = tick && busy && (timer == timeout) && !report_now && (state != REPORT);

    // ---------------- measurement FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            timer       <= '0;
            t1          <= '0;
            width       <= '0;
            busy        <= 1'b0;
            range_cnt   <= '0;
            range_valid <= 1'b0;
            pair_det    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            range_valid <= 1'b0;
            pair_det    <= 1'b0;
            timeout_err <= 1'b0;
            if (interrog) begin
                timer <= '0;
                busy  <= 1'b1;
                state <= WAIT1;
            end else if (timeout_hit) begin
                timeout_err <= 1'b1;
                busy        <= 1'b0;
                state       <= IDLE;
            end else begin
                if (tick && busy && (timer != '1)) begin
                    timer <= timer + 1'b1;
                end
                case (state)
                    IDLE: begin
                    end
                    WAIT1: begin
                        if (tick && above) begin
                            state <= P1;
                            t1    <= timer;
                            width <= WID_W'(1);
                        end
                    end
                    P1: begin
                        if (tick) begin
                            if (!above) begin
                                state <= GAP;
                            end else if (width_full) begin
                                state <= WAIT1;
                            end else begin
                                width <= width + 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (tick) begin
                            if (above && in_tol) begin
                                state <= P2;
                                width <= WID_W'(1);
                            end else if (above && early) begin
                                state <= P1;
                                t1    <= timer;
                                width <= WID_W'(1);
                            end else if (late) begin
                                state <= WAIT1;
                            end
                        end
                    end
                    P2: begin
                        if (tick) begin
                            if (!above) begin
                                // Strobes are raised here so they appear in the REPORT cycle.
                                state    <= REPORT;
                                pair_det <= 1'b1;
                                if (t1 >= reply_delay) begin
                                    range_cnt   <= t1 - reply_delay;
                                    range_valid <= 1'b1;
                                end
                            end else if (width_full) begin
                                state <= WAIT1;
                            end else begin
                                width <= width + 1'b1;
                            end
                        end
                    end
                    REPORT: begin
                        if (range_valid) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= WAIT1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
